// File: rtl/sram_rd_pkg.sv
// sram_rd_pkg: FSM states, SRAM pin constants and default tile geometry for the SRAM tile reader
package sram_rd_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;
  localparam logic SRAM_ADV = 1'b0;
  localparam logic SRAM_WE_N = 1'b1;
  localparam logic [3:0] SRAM_BYTE_EN = 4'b0000;
  localparam int DEF_ROW_STRIDE = 96;
  localparam int DEF_TILE_W_WORDS = 16;
  localparam int DEF_TILE_H = 64;
endpackage

// File: rtl/sram_rd_fifo.sv
// sram_rd_fifo: synchronous FIFO buffering {pixel word, last} between SRAM and the stream output
// ports: clk_100/rst (async, active-low); push/wdata write; pop/rdata read from head; count/full/empty status
module sram_rd_fifo #(
  parameter int W = 33,
  parameter int DEPTH = 8
) (
  input  logic                     clk_100,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  always_comb begin
    do_push = push && !full;
    do_pop = pop && !empty;
    mem_d = mem_q;
    if (do_push) mem_d[wp_q] = wdata;
    wp_d = wp_q + AW'(do_push);
    rp_d = rp_q + AW'(do_pop);
    cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge clk_100) mem_q <= mem_d;
  always_ff @(posedge clk_100 or negedge rst)
    if (!rst) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
    end
  assign rdata = mem_q[rp_q];
  assign count = cnt_q;
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
endmodule

// File: rtl/sram_tile_reader.sv
// sram_tile_reader: fetches one rectangular tile from synchronous SRAM and streams it row-major
// ports: clk_100/rst (async, active-low); start/base_addr request; busy/done status;
//        address_to_sram, chip_en, output_en, write_en_n, adv, byte_en, data_sram to SRAM;
//        out_data/out_valid/out_ready/out_last valid-ready pixel stream
module sram_tile_reader import sram_rd_pkg::*; #(
  parameter int ADDR_W = 18,
  parameter int ROW_STRIDE = DEF_ROW_STRIDE,
  parameter int TILE_W_WORDS = DEF_TILE_W_WORDS,
  parameter int TILE_H = DEF_TILE_H,
  parameter int RD_LAT = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk_100,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] address_to_sram,
  output logic              chip_en,
  output logic              output_en,
  output logic              write_en_n,
  output logic              adv,
  output logic [3:0]        byte_en,
  input  logic [31:0]       data_sram,
  output logic [31:0]       out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);
  localparam int CW = $clog2(TILE_W_WORDS + 1);
  localparam int RW = $clog2(TILE_H + 1);
  localparam int FW = $clog2(FIFO_DEPTH) + 1;
  state_e state_q, state_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d, addr_q, addr_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [RD_LAT-1:0] sr_q, sr_d, lst_q, lst_d;
  logic [FW-1:0] fifo_cnt;
  logic [FW:0] credit;
  logic [32:0] fifo_rdata;
  logic fifo_full, fifo_empty, issue, end_col, end_tile, pop;
  sram_rd_fifo #(.W(33), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_100 (clk_100),
    .rst     (rst),
    .push    (sr_q[RD_LAT-1]),
    .wdata   ({data_sram, lst_q[RD_LAT-1]}),
    .pop     (pop),
    .rdata   (fifo_rdata),
    .count   (fifo_cnt),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );
  always_comb begin
    // reads already in flight hold a FIFO slot, so credit never lets the FIFO overflow
    credit = (FW+1)'(fifo_cnt) + (FW+1)'($countones(sr_q));
    issue = state_q == ISSUE && credit < (FW+1)'(FIFO_DEPTH) && !fifo_full;
    end_col = col_q == CW'(TILE_W_WORDS - 1);
    end_tile = end_col && row_q == RW'(TILE_H - 1);
    pop = out_valid && out_ready;
    state_d = state_q;
    row_base_d = row_base_q;
    col_d = col_q;
    row_d = row_q;
    addr_d = addr_q;
    sr_d = (sr_q << 1) | RD_LAT'(issue);
    lst_d = (lst_q << 1) | RD_LAT'(issue && end_tile);
    if (state_q == IDLE && start) begin
      state_d = ISSUE;
      row_base_d = base_addr;
      col_d = '0;
      row_d = '0;
    end
    if (issue) begin
      addr_d = row_base_q + ADDR_W'(col_q);
      col_d = end_col ? '0 : col_q + 1'b1;
      row_d = row_q + RW'(end_col);
      row_base_d = end_col ? row_base_q + ADDR_W'(ROW_STRIDE) : row_base_q;
      state_d = end_tile ? DRAIN : ISSUE;
    end
    // leave DRAIN on the edge that pops the final word so done follows the last handshake directly
    if (state_q == DRAIN && sr_q == '0 && (fifo_empty || (fifo_cnt == FW'(1) && pop))) state_d = DONE;
    if (state_q == DONE) state_d = IDLE;
  end
  always_ff @(posedge clk_100 or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      row_base_q <= '0;
      addr_q <= '0;
      col_q <= '0;
      row_q <= '0;
      sr_q <= '0;
      lst_q <= '0;
    end else begin
      state_q <= state_d;
      row_base_q <= row_base_d;
      addr_q <= addr_d;
      col_q <= col_d;
      row_q <= row_d;
      sr_q <= sr_d;
      lst_q <= lst_d;
    end
  assign busy = state_q == ISSUE || state_q == DRAIN;
  assign done = state_q == DONE;
  assign chip_en = !busy;
  assign output_en = !busy;
  assign write_en_n = SRAM_WE_N;
  assign adv = SRAM_ADV;
  assign byte_en = SRAM_BYTE_EN;
  assign address_to_sram = addr_q;
  assign out_valid = !fifo_empty;
  assign out_data = out_valid ? fifo_rdata[32:1] : '0;
  assign out_last = out_valid && fifo_rdata[0];
endmodule

// File: tb/tb_sram_tile_reader.sv
// tb_sram_tile_reader: scoreboard bench driving three readers with RD_LAT 1, 2 and 4 in lockstep
module tb_sram_tile_reader;
  localparam int NW = 1024;
  logic clk_100 = 0, rst = 0, start = 0, rdy = 1, rnd = 0;
  logic [17:0] base_addr = '0;
  logic busy[3], done[3], chip_en[3], output_en[3], write_en_n[3], adv[3], out_valid[3], out_last[3];
  logic [17:0] addr[3];
  logic [3:0] byte_en[3];
  logic [31:0] data_sram[3], out_data[3];
  logic [32:0] sb[3][$];
  logic prev_last[3] = '{0, 0, 0};
  int hs[3] = '{0, 0, 0}, hs0[3] = '{0, 0, 0}, done_cnt[3] = '{0, 0, 0};
  int nchk = 0, nerr = 0;
  always #5 clk_100 = ~clk_100;
  function automatic int rd_of(input int i);
    return i == 0 ? 1 : i == 1 ? 2 : 4;
  endfunction
  function automatic logic [17:0] addr_of(input logic [17:0] b, input int idx);
    return b + 18'(idx / 16 * 96) + 18'(idx % 16);
  endfunction
  function automatic logic [31:0] dat_of(input logic [17:0] a);
    return {8'hA5, 6'd0, a};
  endfunction
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int RD = (g == 0) ? 1 : (g == 1) ? 2 : 4;
    logic [17:0] pipe[4];
    sram_tile_reader #(.RD_LAT(RD)) dut (
      .clk_100         (clk_100),
      .rst             (rst),
      .start           (start),
      .base_addr       (base_addr),
      .busy            (busy[g]),
      .done            (done[g]),
      .address_to_sram (addr[g]),
      .chip_en         (chip_en[g]),
      .output_en       (output_en[g]),
      .write_en_n      (write_en_n[g]),
      .adv             (adv[g]),
      .byte_en         (byte_en[g]),
      .data_sram       (data_sram[g]),
      .out_data        (out_data[g]),
      .out_valid       (out_valid[g]),
      .out_ready       (rdy),
      .out_last        (out_last[g])
    );
    always @(posedge clk_100) begin
      pipe[0] <= addr[g];
      for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
    end
    assign data_sram[g] = dat_of(RD == 1 ? addr[g] : pipe[(RD > 1) ? RD - 2 : 0]);
  end
  always @(negedge clk_100) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst) prev_last[i] <= 0;
      else begin
        if (out_valid[i]) begin
          if (sb[i].size() == 0) check($sformatf("extra_word%0d", i), out_valid[i], 0);
          else begin
            check($sformatf("data%0d", i), out_data[i], sb[i][0][32:1]);
            check($sformatf("last%0d", i), out_last[i], sb[i][0][0]);
            if (rdy) begin
              void'(sb[i].pop_front());
              hs[i] <= hs[i] + 1;
            end
          end
        end
        if (done[i]) begin
          check($sformatf("done_after_last%0d", i), prev_last[i], 1);
          done_cnt[i] <= done_cnt[i] + 1;
        end
        prev_last[i] <= out_valid[i] && rdy && out_last[i];
      end
    end
  end
  task automatic tick();
    @(posedge clk_100);
    #1;
    if (rnd) rdy = 1'($urandom_range(0, 1));
  endtask
  task automatic start_tile(input logic [17:0] b);
    base_addr = b;
    start = 1;
    for (int i = 0; i < 3; i++) begin
      hs0[i] = hs[i];
      for (int n = 0; n < NW; n++) sb[i].push_back({dat_of(addr_of(b, n)), n == NW - 1});
    end
    tick();
    start = 0;
  endtask
  task automatic wait_tiles(input int t);
    for (int c = 0; c < 8000 && !(done_cnt[0] >= t && done_cnt[1] >= t && done_cnt[2] >= t); c++) tick();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("tile_done%0d", i), done_cnt[i], t);
      check($sformatf("words%0d", i), hs[i] - hs0[i], NW);
      check($sformatf("sb_left%0d", i), sb[i].size(), 0);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("busy_after%0d", i), busy[i], 0);
      check($sformatf("done_pulse%0d", i), done[i], 0);
    end
  endtask
  task automatic wait_hs(input int n);
    for (int c = 0; c < 4000 && hs[1] - hs0[1] < n; c++) tick();
    check("hs_reached", hs[1] - hs0[1] >= n, 1);
  endtask
  task automatic check_reset();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_busy%0d", i), busy[i], 0);
      check($sformatf("rst_done%0d", i), done[i], 0);
      check($sformatf("rst_valid%0d", i), out_valid[i], 0);
      check($sformatf("rst_last%0d", i), out_last[i], 0);
      check($sformatf("rst_data%0d", i), out_data[i], 0);
      check($sformatf("rst_addr%0d", i), addr[i], 0);
      check($sformatf("rst_ce%0d", i), chip_en[i], 1);
      check($sformatf("rst_oe%0d", i), output_en[i], 1);
      check($sformatf("we_n%0d", i), write_en_n[i], 1);
      check($sformatf("adv%0d", i), adv[i], 0);
      check($sformatf("byte_en%0d", i), byte_en[i], 0);
    end
  endtask
  initial begin
    repeat (3) tick();
    check_reset();
    rst = 1;
    repeat (2) tick();
    start_tile(18'h0);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("busy_on%0d", i), busy[i], 1);
      check($sformatf("ce_on%0d", i), chip_en[i], 0);
      check($sformatf("oe_on%0d", i), output_en[i], 0);
    end
    tick();
    for (int i = 0; i < 3; i++) check($sformatf("first_addr%0d", i), addr[i], 0);
    tick();
    for (int i = 0; i < 3; i++) check($sformatf("valid_e2_%0d", i), out_valid[i], rd_of(i) <= 1);
    tick();
    for (int i = 0; i < 3; i++) check($sformatf("valid_e3_%0d", i), out_valid[i], rd_of(i) <= 2);
    wait_tiles(1);
    start_tile(18'h200);
    wait_hs(300);
    rdy = 0;
    repeat (20) tick();
    for (int i = 0; i < 3; i++) check($sformatf("stall_addr%0d", i), addr[i], addr_of(18'h200, hs[i] - hs0[i] + 7));
    repeat (29) tick();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("held_addr%0d", i), addr[i], addr_of(18'h200, hs[i] - hs0[i] + 7));
      check($sformatf("stall_valid%0d", i), out_valid[i], 1);
    end
    rdy = 1;
    wait_tiles(2);
    start_tile(18'h3FFF8);
    tick();
    for (int i = 0; i < 3; i++) check($sformatf("wrap_addr%0d", i), addr[i], 18'h3FFF8);
    wait_tiles(3);
    start_tile(18'h40);
    repeat (9) tick();
    base_addr = 18'h3000;
    start = 1;
    tick();
    start = 0;
    repeat (189) tick();
    base_addr = 18'h1234;
    start = 1;
    tick();
    start = 0;
    wait_tiles(4);
    start_tile(18'h0);
    wait_hs(300);
    #3 rst = 0;
    #1 check_reset();
    for (int i = 0; i < 3; i++) sb[i].delete();
    tick();
    rst = 1;
    tick();
    start_tile(18'h100);
    tick();
    for (int i = 0; i < 3; i++) check($sformatf("restart_addr%0d", i), addr[i], 18'h100);
    wait_tiles(5);
    rnd = 1;
    start_tile(18'h2A5C0);
    wait_tiles(6);
    rnd = 0;
    rdy = 1;
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
